// File: rtl/dmem_wait.sv
// Word-organised data RAM behind a valid/ready port with programmable wait states.
// Byte/half/word accesses with RV32 size codes; misaligned or illegal accesses respond with an error.
module dmem_wait #(
  parameter int    ADDR_W  = 18,
  parameter int    LATENCY = 2,
  parameter string MEMFILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        busy_q;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // With zero wait states the commit edge is the accept edge, so operands come straight from the port.
  logic        accept;
  logic        commit;
  logic        c_we;
  logic [2:0]  c_size;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  assign accept  = (state_q == IDLE) && req_valid;
  assign commit  = !reset && ((accept && (LAT == 4'd0)) ||
                              ((state_q == WAIT) && (cnt_q <= 4'd1)));
  assign c_we    = (state_q == IDLE) ? req_we    : we_q;
  assign c_size  = (state_q == IDLE) ? req_size  : size_q;
  assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  logic [ADDR_W-1:0] widx;
  assign widx = c_addr[ADDR_W+1:2];

  logic c_err;
  always_comb begin
    c_err = 1'b0;
    case (c_size)
      3'b000:  c_err = 1'b0;
      3'b001:  c_err = c_addr[0];
      3'b010:  c_err = |c_addr[1:0];
      3'b100:  c_err = c_we;
      3'b101:  c_err = c_we | c_addr[0];
      default: c_err = 1'b1;
    endcase
  end

  logic [3:0]  be;
  logic [31:0] wlane;
  always_comb begin
    be    = 4'b0000;
    wlane = c_wdata;
    case (c_size[1:0])
      2'b00: begin
        be    = 4'b0001 << c_addr[1:0];
        wlane = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        be    = c_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{c_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  logic wr_en;
  assign wr_en = commit && c_we && !c_err;

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_en && be[l]) mem[widx][8*l +: 8] <= wlane[8*l +: 8];
    end
  end

  logic [31:0] rword;
  logic [31:0] rsh;
  logic [31:0] ld_data;
  assign rword = mem[widx];
  assign rsh   = rword >> {c_addr[1:0], 3'b000};

  always_comb begin
    ld_data = 32'd0;
    case (c_size)
      3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_data = {{16{rsh[15]}}, rsh[15:0]};
      3'b010:  ld_data = rword;
      3'b100:  ld_data = {24'd0, rsh[7:0]};
      3'b101:  ld_data = {16'd0, rsh[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

  // Address bits above the RAM window alias by design.
  logic unused_addr;
  assign unused_addr = ^c_addr[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= LAT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (LAT == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        rvalid_q <= 1'b1;
        err_q    <= c_err;
        rdata_q  <= (c_we || c_err) ? 32'd0 : ld_data;
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: a LATENCY=2 instance for the functional plan and a
// LATENCY=0 instance for back-to-back throughput.
module tb_dmem_wait;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_size = 3'b010;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        v0 = 1'b0, we0 = 1'b0;
  logic [2:0]  sz0 = 3'b010;
  logic [31:0] a0 = 32'd0, wd0 = 32'd0;
  logic        rdy0, rv0, err0, busy0;
  logic [31:0] rd0;

  int errs = 0;
  int checks = 0;

  dmem_wait #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  dmem_wait #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_size(sz0), .req_addr(a0), .req_wdata(wd0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
    .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=2 instance; a different request is held on the port while busy.
  task automatic txn(input string tag, input logic we, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_we = ~we; req_addr = a ^ 32'h4; req_wdata = ~wd;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rdy"}, req_ready, 0);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_err"}, resp_err, exp_err);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_rdy_resp"}, req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_pulse"}, resp_valid, 0);
    chk({tag, "_hold"}, resp_rdata, exp_rd);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rv", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", rdy0, 1);
    reset = 1'b0;

    txn("sw100",  1, SZ_W,  32'h100, 32'hDEADBEEF, 32'h0,        0);
    txn("lw100",  0, SZ_W,  32'h100, 32'h0,        32'hDEADBEEF, 0);
    txn("sw200",  1, SZ_W,  32'h200, 32'h11223344, 32'h0,        0);
    txn("sb202",  1, SZ_B,  32'h202, 32'h123456AA, 32'h0,        0);
    txn("lw200",  0, SZ_W,  32'h200, 32'h0,        32'h11AA3344, 0);
    txn("lb202",  0, SZ_B,  32'h202, 32'h0,        32'hFFFFFFAA, 0);
    txn("lbu202", 0, SZ_BU, 32'h202, 32'h0,        32'h000000AA, 0);
    txn("sw200b", 1, SZ_W,  32'h200, 32'h80015A5A, 32'h0,        0);
    txn("lh202",  0, SZ_H,  32'h202, 32'h0,        32'hFFFF8001, 0);
    txn("lhu202", 0, SZ_HU, 32'h202, 32'h0,        32'h00008001, 0);
    txn("lh200",  0, SZ_H,  32'h200, 32'h0,        32'h00005A5A, 0);
    txn("lh201",  0, SZ_H,  32'h201, 32'h0,        32'h0,        1);
    txn("sh200",  1, SZ_H,  32'h200, 32'hFFFFBEEF, 32'h0,        0);
    txn("lw200c", 0, SZ_W,  32'h200, 32'h0,        32'h8001BEEF, 0);
    txn("sw102",  1, SZ_W,  32'h102, 32'h12345678, 32'h0,        1);
    txn("lw100b", 0, SZ_W,  32'h100, 32'h0,        32'hDEADBEEF, 0);
    txn("sbu100", 1, SZ_BU, 32'h100, 32'h0,        32'h0,        1);
    txn("lw100c", 0, SZ_W,  32'h100, 32'h0,        32'hDEADBEEF, 0);
    txn("sz011",  0, 3'b011, 32'h100, 32'h0,       32'h0,        1);
    txn("sz111",  0, 3'b111, 32'h100, 32'h0,       32'h0,        1);
    txn("lw101",  0, SZ_W,  32'h101, 32'h0,        32'h0,        1);
    txn("alias",  0, SZ_W,  32'h1100, 32'h0,       32'hDEADBEEF, 0);
    txn("lb103",  0, SZ_B,  32'h103, 32'h0,        32'hFFFFFFDE, 0);
    txn("sb1101", 1, SZ_B,  32'h1101, 32'h0,       32'h0,        0);
    txn("lw100d", 0, SZ_W,  32'h100, 32'h0,        32'hDEAD00EF, 0);

    // Reset during WAIT drops the pending store.
    txn("sw300", 1, SZ_W, 32'h300, 32'h0BADF00D, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h300; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_ready", req_ready, 1);
    chk("rstw_busy0", busy, 0);
    chk("rstw_rv", resp_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_norv", resp_valid, 0);
    end
    txn("lw300", 0, SZ_W, 32'h300, 32'h0, 32'h0BADF00D, 0);

    // Zero wait states: store then load back, then continuous requests.
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; sz0 = SZ_W; a0 = 32'h40; wd0 = 32'h12345678;
    @(negedge clk);
    chk("l0_st_rv", rv0, 1);
    chk("l0_st_rdy", rdy0, 0);
    v0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk("l0_idle_rdy", rdy0, 1);
    v0 = 1'b1;
    @(negedge clk);
    chk("l0_ld_rv", rv0, 1);
    chk("l0_ld_data", rd0, 32'h12345678);
    chk("l0_ld_err", err0, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l0_rv_pat", rv0, 32'(i % 2));
      chk("l0_rdy_pat", rdy0, 32'((i + 1) % 2));
      if (rv0) pulses++;
    end
    chk("l0_pulses", pulses, 3);
    v0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
